audio_cfg_seq: RTL and testbench

AUDIO_CFG_SEQ -- requirements
Module: audio_cfg_seq

---
 rtl/audio_cfg_seq.sv | 179 +++++++++++++++++
 tb/tb_audio_cfg_seq.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/audio_cfg_seq.sv
// audio_cfg_seq: I2C write sequencer that plays a codec init table and single host register writes
module audio_cfg_seq #(
    parameter int         CLK_DIV  = 125,
    parameter logic [6:0] DEV_ADDR = 7'h1A
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic       wr_req,
    input  logic [6:0] wr_addr,
    input  logic [8:0] wr_data,
    output logic       wr_ack,
    output logic       busy,
    output logic       init_done,
    output logic       ack_err,
    output logic       sclk,
    output logic       sdat_oe,
    input  logic       sdat_in
);
    typedef enum logic [2:0] {IDLE, START, BIT, ACK, STOP, GAP} state_t;

    state_t      state;
    logic [9:0]  qcnt;
    logic [1:0]  q;
    logic [4:0]  ptr;
    logic [3:0]  idx;
    logic [1:0]  retry;
    logic        is_init;
    logic        pend;
    logic        nack;
    logic [6:0]  h_addr;
    logic [8:0]  h_data;
    logic [15:0] entry;
    logic [23:0] frame;
    logic [4:0]  pm1;
    logic        tick;
    logic        nxt_bit;

    function automatic logic [15:0] tbl(input logic [3:0] i);
        case (i)
            4'd0:    tbl = {7'h0F, 9'h000};
            4'd1:    tbl = {7'h00, 9'h097};
            4'd2:    tbl = {7'h01, 9'h097};
            4'd3:    tbl = {7'h02, 9'h079};
            4'd4:    tbl = {7'h03, 9'h079};
            4'd5:    tbl = {7'h04, 9'h012};
            4'd6:    tbl = {7'h05, 9'h000};
            4'd7:    tbl = {7'h06, 9'h067};
            4'd8:    tbl = {7'h07, 9'h042};
            4'd9:    tbl = {7'h08, 9'h000};
            default: tbl = {7'h09, 9'h001};
        endcase
    endfunction

    // current register/data pair: table entry during init, captured host pair otherwise
    always_comb entry = is_init ? tbl(idx) : {h_addr, h_data};

    assign frame   = {DEV_ADDR, 1'b0, entry};
    assign pm1     = ptr - 5'd1;
    assign nxt_bit = frame[pm1];
    assign tick    = qcnt == 10'(CLK_DIV - 1);
    assign busy    = state != IDLE;

    // frame sequencer: outputs are updated at quarter boundaries for the quarter being entered
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            qcnt      <= '0;
            q         <= '0;
            ptr       <= '0;
            idx       <= '0;
            retry     <= '0;
            is_init   <= 1'b0;
            pend      <= 1'b0;
            nack      <= 1'b0;
            h_addr    <= '0;
            h_data    <= '0;
            wr_ack    <= 1'b0;
            init_done <= 1'b0;
            ack_err   <= 1'b0;
            sclk      <= 1'b1;
            sdat_oe   <= 1'b0;
        end else begin
            wr_ack <= 1'b0;
            if (start && state != IDLE) pend <= 1'b1;
            if (state == IDLE) begin
                qcnt <= '0;
                q    <= '0;
                if (start || pend) begin
                    state     <= START;
                    is_init   <= 1'b1;
                    idx       <= '0;
                    retry     <= '0;
                    nack      <= 1'b0;
                    pend      <= 1'b0;
                    init_done <= 1'b0;
                    ack_err   <= 1'b0;
                end else if (wr_req) begin
                    state   <= START;
                    is_init <= 1'b0;
                    h_addr  <= wr_addr;
                    h_data  <= wr_data;
                    retry   <= '0;
                    nack    <= 1'b0;
                end
            end else begin
                qcnt <= tick ? '0 : qcnt + 10'd1;
                if (state == ACK && q == 2'd2 && tick && sdat_in) nack <= 1'b1;
                if (tick) begin
                    q <= q + 2'd1;
                    case (state)
                        START: begin
                            if (q == 2'd1) sdat_oe <= 1'b1;
                            if (q == 2'd3) begin
                                state   <= BIT;
                                ptr     <= 5'd23;
                                sclk    <= 1'b0;
                                sdat_oe <= ~frame[23];
                            end
                        end
                        BIT: begin
                            if (q == 2'd1) sclk <= 1'b1;
                            if (q == 2'd3) begin
                                sclk <= 1'b0;
                                if (ptr[2:0] == 3'd0) begin
                                    state   <= ACK;
                                    sdat_oe <= 1'b0;
                                end else begin
                                    ptr     <= pm1;
                                    sdat_oe <= ~nxt_bit;
                                end
                            end
                        end
                        ACK: begin
                            if (q == 2'd1) sclk <= 1'b1;
                            if (q == 2'd3) begin
                                sclk <= 1'b0;
                                if (nack || ptr == 5'd0) begin
                                    state   <= STOP;
                                    sdat_oe <= 1'b1;
                                end else begin
                                    state   <= BIT;
                                    ptr     <= pm1;
                                    sdat_oe <= ~nxt_bit;
                                end
                            end
                        end
                        STOP: begin
                            if (q == 2'd1) sclk <= 1'b1;
                            if (q == 2'd2) sdat_oe <= 1'b0;
                            if (q == 2'd3) state <= GAP;
                        end
                        GAP: begin
                            if (q == 2'd3) begin
                                nack <= 1'b0;
                                if (nack && retry != 2'd2) begin
                                    retry <= retry + 2'd1;
                                    state <= START;
                                end else begin
                                    if (nack) ack_err <= 1'b1;
                                    retry <= '0;
                                    if (is_init && idx != 4'd10) begin
                                        idx   <= idx + 4'd1;
                                        state <= START;
                                    end else begin
                                        state <= IDLE;
                                        if (is_init) init_done <= 1'b1;
                                        else wr_ack <= 1'b1;
                                    end
                                end
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end
endmodule

// File: tb/tb_audio_cfg_seq.sv
// tb_audio_cfg_seq: scoreboard bench with an I2C slave model decoding frames and injecting NACKs
module tb_audio_cfg_seq;
    localparam int CLK_DIV = 4;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       start = 1'b0;
    logic       wr_req = 1'b0;
    logic [6:0] wr_addr = '0;
    logic [8:0] wr_data = '0;
    logic       wr_ack, busy, init_done, ack_err, sclk, sdat_oe, sdat_in;
    logic       slave_low = 1'b0;

    typedef struct packed {
        logic [1:0] nb;
        logic [7:0] b0;
        logic [7:0] b1;
        logic [7:0] b2;
    } rec_t;

    rec_t        exp_q[$];
    bit          nack_map[64];
    int          total = 0;
    int          bad = 0;
    int          fno = 0;
    int          fcur = 0;
    int          bitc = 0;
    int          bytec = 0;
    int          wr_ack_cnt = 0;
    logic [7:0]  shreg = '0;
    logic [7:0]  got[3];
    logic        ack_phase = 1'b0;
    logic        ack_clk = 1'b0;
    logic        pscl = 1'b1;
    logic        psda = 1'b1;
    logic [15:0] tbl[11] = '{{7'h0F, 9'h000}, {7'h00, 9'h097}, {7'h01, 9'h097}, {7'h02, 9'h079},
                             {7'h03, 9'h079}, {7'h04, 9'h012}, {7'h05, 9'h000}, {7'h06, 9'h067},
                             {7'h07, 9'h042}, {7'h08, 9'h000}, {7'h09, 9'h001}};

    assign sdat_in = ~(sdat_oe | slave_low);

    always #5 clk = ~clk;

    audio_cfg_seq #(.CLK_DIV(CLK_DIV), .DEV_ADDR(7'h1A)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .wr_req(wr_req),
        .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack), .busy(busy),
        .init_done(init_done), .ack_err(ack_err), .sclk(sclk), .sdat_oe(sdat_oe),
        .sdat_in(sdat_in)
    );

    always @(negedge clk) if (wr_ack) wr_ack_cnt++;

    // slave: decodes START/bits/STOP on the bus, ACKs each byte unless told to NACK the address byte
    always @(negedge clk) begin
        logic sda;
        rec_t o, e;
        sda = sdat_in;
        if (!reset_n) begin
            slave_low = 1'b0;
            bitc = 0;
            bytec = 0;
            ack_phase = 1'b0;
            ack_clk = 1'b0;
        end else if (sclk && pscl && psda && !sda) begin
            bitc = 0;
            bytec = 0;
            ack_phase = 1'b0;
            ack_clk = 1'b0;
            fcur = fno;
            fno++;
            got = '{default: 8'h00};
        end else if (sclk && pscl && !psda && sda) begin
            o = {bytec[1:0], got[0], got[1], got[2]};
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL frame: got unexpected frame %h, none required", o);
            end else begin
                e = exp_q.pop_front();
                if (o !== e) begin
                    bad++;
                    $display("FAIL frame: got %h want %h", o, e);
                end
            end
            bitc = 0;
        end else if (sclk && !pscl) begin
            if (bitc < 8) begin
                shreg = {shreg[6:0], sda};
                bitc++;
            end else ack_clk = 1'b1;
        end else if (!sclk && pscl) begin
            if (bitc == 8 && !ack_phase) begin
                ack_phase = 1'b1;
                slave_low = !(bytec == 0 && nack_map[fcur]);
            end else if (ack_phase && ack_clk) begin
                slave_low = 1'b0;
                if (bytec < 3) got[bytec] = shreg;
                bytec++;
                bitc = 0;
                ack_phase = 1'b0;
                ack_clk = 1'b0;
            end
        end
        pscl = sclk;
        psda = sda;
    end

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    // expected frames of one init run starting at bus frame f0, honouring the NACK plan
    task automatic push_run(input int f0, output logic err);
        int f;
        f = f0;
        err = 1'b0;
        for (int e = 0; e < 11; e++) begin
            for (int t = 0; t < 3; t++) begin
                if (nack_map[f]) begin
                    exp_q.push_back({2'd1, 8'h34, 8'h00, 8'h00});
                    f++;
                    if (t == 2) err = 1'b1;
                end else begin
                    exp_q.push_back({2'd3, 8'h34, tbl[e][15:8], tbl[e][7:0]});
                    f++;
                    break;
                end
            end
        end
    endtask

    task automatic wait_init(input int maxc, output logic to, output logic pb);
        int n;
        n = 0;
        pb = busy;
        while (!init_done && n < maxc) begin
            pb = busy;
            @(negedge clk);
            n++;
        end
        to = !init_done;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        total += 6;
        if (sclk !== 1'b1)      begin bad++; $display("FAIL rst_sclk: got %b want 1", sclk); end
        if (sdat_oe !== 1'b0)   begin bad++; $display("FAIL rst_oe: got %b want 0", sdat_oe); end
        if (busy !== 1'b0)      begin bad++; $display("FAIL rst_busy: got %b want 0", busy); end
        if (init_done !== 1'b0) begin bad++; $display("FAIL rst_done: got %b want 0", init_done); end
        if (ack_err !== 1'b0)   begin bad++; $display("FAIL rst_err: got %b want 0", ack_err); end
        if (wr_ack !== 1'b0)    begin bad++; $display("FAIL rst_ack: got %b want 0", wr_ack); end
        reset_n = 1'b1;
        repeat (20) @(negedge clk);
        total++;
        if (busy !== 1'b0 || sclk !== 1'b1) begin
            bad++;
            $display("FAIL no_auto_init: got busy=%b sclk=%b want busy=0 sclk=1", busy, sclk);
        end
    endtask

    task automatic test_init();
        logic err, to, pb;
        fno = 0;
        nack_map = '{default: 1'b0};
        push_run(0, err);
        pulse_start();
        wait_init(8000, to, pb);
        total += 4;
        if (to) begin bad++; $display("FAIL init_timeout: got init_done=0 want 1"); end
        else if (pb !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL init_done_edge: got prev_busy=%b busy=%b want 1 0", pb, busy);
        end
        if (ack_err !== err) begin bad++; $display("FAIL init_err: got %b want %b", ack_err, err); end
        if (fno !== 11) begin bad++; $display("FAIL init_frames: got %0d want 11", fno); end
        if (exp_q.size() != 0) begin bad++; $display("FAIL init_left: got %0d pending want 0", exp_q.size()); end
    endtask

    task automatic test_write();
        int n, c0;
        c0 = wr_ack_cnt;
        n = 0;
        exp_q.push_back({2'd3, 8'h34, 7'h04, 1'b1, 8'hFF});
        @(negedge clk);
        wr_addr = 7'h04;
        wr_data = 9'h1FF;
        wr_req = 1'b1;
        repeat (3) @(negedge clk);
        wr_addr = 7'h7F;
        wr_data = 9'h000;
        while (!wr_ack && n < 2000) begin @(negedge clk); n++; end
        total += 2;
        if (!wr_ack) begin bad++; $display("FAIL wr_timeout: got wr_ack=0 want 1"); end
        if (busy !== 1'b0) begin bad++; $display("FAIL wr_busy_fall: got busy=%b want 0 with wr_ack", busy); end
        wr_req = 1'b0;
        repeat (20) @(negedge clk);
        total += 3;
        if (wr_ack_cnt - c0 != 1) begin bad++; $display("FAIL wr_ack_count: got %0d want 1", wr_ack_cnt - c0); end
        if (busy !== 1'b0) begin bad++; $display("FAIL wr_idle: got busy=%b want 0", busy); end
        if (exp_q.size() != 0) begin bad++; $display("FAIL wr_left: got %0d pending want 0", exp_q.size()); end
    endtask

    task automatic test_nack_retry();
        logic err, to, pb;
        fno = 0;
        nack_map = '{default: 1'b0};
        nack_map[3] = 1'b1;
        nack_map[4] = 1'b1;
        push_run(0, err);
        pulse_start();
        wait_init(10000, to, pb);
        total += 4;
        if (to) begin bad++; $display("FAIL retry_timeout: got init_done=0 want 1"); end
        if (ack_err !== err) begin bad++; $display("FAIL retry_err: got %b want %b", ack_err, err); end
        if (fno !== 13) begin bad++; $display("FAIL retry_frames: got %0d want 13", fno); end
        if (exp_q.size() != 0) begin bad++; $display("FAIL retry_left: got %0d pending want 0", exp_q.size()); end
    endtask

    task automatic test_nack_fail();
        logic err, to, pb;
        fno = 0;
        nack_map = '{default: 1'b0};
        nack_map[5] = 1'b1;
        nack_map[6] = 1'b1;
        nack_map[7] = 1'b1;
        push_run(0, err);
        pulse_start();
        wait_init(10000, to, pb);
        total += 4;
        if (to) begin bad++; $display("FAIL fail_timeout: got init_done=0 want 1"); end
        if (ack_err !== 1'b1) begin bad++; $display("FAIL fail_err: got %b want 1", ack_err); end
        if (fno !== 13) begin bad++; $display("FAIL fail_frames: got %0d want 13", fno); end
        if (exp_q.size() != 0) begin bad++; $display("FAIL fail_left: got %0d pending want 0", exp_q.size()); end
        nack_map = '{default: 1'b0};
    endtask

    task automatic test_start_during();
        logic err;
        int n, c0;
        n = 0;
        c0 = wr_ack_cnt;
        fno = 0;
        push_run(0, err);
        push_run(11, err);
        exp_q.push_back({2'd3, 8'h34, 7'h05, 1'b0, 8'hAA});
        pulse_start();
        total += 2;
        if (ack_err !== 1'b0) begin bad++; $display("FAIL err_clear: got %b want 0", ack_err); end
        if (init_done !== 1'b0) begin bad++; $display("FAIL done_clear: got %b want 0", init_done); end
        repeat (100) @(negedge clk);
        wr_addr = 7'h05;
        wr_data = 9'h0AA;
        wr_req = 1'b1;
        pulse_start();
        while (!wr_ack && n < 14000) begin @(negedge clk); n++; end
        wr_req = 1'b0;
        total += 4;
        if (!wr_ack) begin bad++; $display("FAIL arb_timeout: got wr_ack=0 want 1"); end
        if (init_done !== 1'b1) begin bad++; $display("FAIL arb_done: got %b want 1", init_done); end
        if (fno !== 23) begin bad++; $display("FAIL arb_frames: got %0d want 23", fno); end
        if (exp_q.size() != 0) begin bad++; $display("FAIL arb_left: got %0d pending want 0", exp_q.size()); end
        repeat (10) @(negedge clk);
        total++;
        if (wr_ack_cnt - c0 != 1) begin bad++; $display("FAIL arb_ack_count: got %0d want 1", wr_ack_cnt - c0); end
    endtask

    task automatic test_reset_mid();
        int act;
        act = 0;
        fno = 0;
        pulse_start();
        repeat (200) @(negedge clk);
        total++;
        if (busy !== 1'b1) begin bad++; $display("FAIL mid_busy: got %b want 1 before reset", busy); end
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        total += 3;
        if (sclk !== 1'b1) begin bad++; $display("FAIL mid_sclk: got %b want 1", sclk); end
        if (sdat_oe !== 1'b0) begin bad++; $display("FAIL mid_oe: got %b want 0", sdat_oe); end
        if (busy !== 1'b0) begin bad++; $display("FAIL mid_busy_rst: got %b want 0", busy); end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (1500) begin
            @(negedge clk);
            if (sclk !== 1'b1 || sdat_oe !== 1'b0 || busy !== 1'b0) act++;
        end
        total += 3;
        if (act != 0) begin bad++; $display("FAIL mid_quiet: got %0d active cycles want 0", act); end
        if (init_done !== 1'b0) begin bad++; $display("FAIL mid_done: got %b want 0", init_done); end
        if (exp_q.size() != 0) begin bad++; $display("FAIL mid_left: got %0d pending want 0", exp_q.size()); end
    endtask

    initial begin
        test_reset();
        test_init();
        test_write();
        test_nack_retry();
        test_nack_fail();
        test_start_during();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
